cmd_arbiter: RTL and testbench

- Arbitrates the cmd_proc command path between two requesters: the UART/Bluetooth command stream and the tour-move sequencer.
- Buffers UART commands in a small FIFO while a tour owns the datapath, then presents one command at a time to cmd_proc with a registered cmd/cmd_rdy handshake.
- Tracks completion via send_resp, routes the completion pulse back to the issuing requester, and flags a sticky timeout if cmd_proc never responds.

---
 rtl/cmd_arbiter.sv | 130 +++++++++++++
 tb/tb_cmd_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter.sv
// Arbitrates cmd_proc between the UART command stream (buffered in a FIFO) and the
// tour-move sequencer, routes completion back to the issuer and flags response timeouts.
module cmd_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int RESP_TIMEOUT = 2**20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   uart_cmd,
    input  logic                          uart_cmd_rdy,
    output logic                          clr_uart_rdy,
    input  logic [15:0]                   tour_cmd,
    input  logic                          tour_cmd_rdy,
    output logic                          clr_tour_rdy,
    input  logic                          tour_active,
    output logic [15:0]                   cmd,
    output logic                          cmd_rdy,
    input  logic                          clr_cmd_rdy,
    input  logic                          send_resp,
    output logic                          uart_done,
    output logic                          tour_done,
    output logic                          cur_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(RESP_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t          state, state_nxt;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [TW-1:0]   timer;
    logic            fifo_full, fifo_push, fifo_pop;
    logic            tour_take, finish, timed_out;

    always_comb begin
        state_nxt = state;
        tour_take = 1'b0;
        fifo_pop  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (tour_active && tour_cmd_rdy) begin
                    tour_take = 1'b1;
                    state_nxt = ISSUE;
                end else if (!tour_active && fifo_cnt != '0) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (clr_cmd_rdy) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (send_resp || timer == T_LAST) begin
                    finish    = 1'b1;
                    timed_out = !send_resp;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO still takes a word when the head leaves on the same edge.
    assign fifo_full    = (fifo_cnt == CNT_FULL);
    assign fifo_push    = uart_cmd_rdy && (!fifo_full || fifo_pop);
    assign clr_uart_rdy = fifo_push;
    assign clr_tour_rdy = tour_take;
    assign uart_done    = finish && !cur_src;
    assign tour_done    = finish && cur_src;

    always_ff @(posedge clk) begin
        if (rst_n && fifo_push) mem[wr_ptr] <= uart_cmd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            cmd         <= 16'h0000;
            cmd_rdy     <= 1'b0;
            cur_src     <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (fifo_push && !fifo_pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!fifo_push && fifo_pop)
                fifo_cnt <= fifo_cnt - 1'b1;

            if (tour_take) begin
                cmd     <= tour_cmd;
                cur_src <= 1'b1;
                cmd_rdy <= 1'b1;
            end else if (fifo_pop) begin
                cmd     <= mem[rd_ptr];
                cur_src <= 1'b0;
                cmd_rdy <= 1'b1;
            end else if (state == ISSUE && clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            if (state == ISSUE && clr_cmd_rdy)
                timer <= '0;
            else if (state == WAIT_RESP)
                timer <= timer + 1'b1;

            // A timeout raised on the same edge as err_clr must not be lost.
            if (timed_out)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_cmd_arbiter;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] uart_cmd = '0;
    logic        uart_cmd_rdy = 1'b0;
    logic        clr_uart_rdy;
    logic [15:0] tour_cmd = '0;
    logic        tour_cmd_rdy = 1'b0;
    logic        clr_tour_rdy;
    logic        tour_active = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic        uart_done;
    logic        tour_done;
    logic        cur_src;
    logic [2:0]  fifo_cnt;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: a queue for the FIFO plus the life of the single in-flight command.
    logic [15:0] mq[$];
    int          m_phase;      // 0 = nothing in flight, 1 = offered to cmd_proc, 2 = executing
    logic [15:0] m_cmd;
    bit          m_src, m_err, m_accept, m_tour_take;
    int          m_wait;

    logic [15:0] to_push[$];
    logic [15:0] issued[$];

    cmd_arbiter #(.FIFO_DEPTH(DEPTH), .RESP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_cmd(uart_cmd), .uart_cmd_rdy(uart_cmd_rdy), .clr_uart_rdy(clr_uart_rdy),
        .tour_cmd(tour_cmd), .tour_cmd_rdy(tour_cmd_rdy), .clr_tour_rdy(clr_tour_rdy),
        .tour_active(tour_active),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .uart_done(uart_done), .tour_done(tour_done), .cur_src(cur_src),
        .fifo_cnt(fifo_cnt), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_phase = 0; m_cmd = '0; m_src = 0; m_err = 0; m_wait = 0;
        m_accept = 0; m_tour_take = 0;
    endtask

    // Check every output against the model for the current inputs, then advance one clock.
    task automatic applyStimulus();
        bit tour_go, uart_go, fin, tmo;
        #1;
        tour_go  = (m_phase == 0) && tour_active && tour_cmd_rdy;
        uart_go  = (m_phase == 0) && !tour_go && !tour_active && (mq.size() != 0);
        m_accept = uart_cmd_rdy && ((mq.size() < DEPTH) || uart_go);
        m_tour_take = tour_go;
        fin = (m_phase == 2) && (send_resp || m_wait == TMO - 1);
        tmo = fin && !send_resp;

        checkOutput("clr_uart_rdy", 32'(clr_uart_rdy), 32'(m_accept));
        checkOutput("clr_tour_rdy", 32'(clr_tour_rdy), 32'(tour_go));
        checkOutput("cmd",          32'(cmd),          32'(m_cmd));
        checkOutput("cmd_rdy",      32'(cmd_rdy),      32'(m_phase == 1));
        checkOutput("cur_src",      32'(cur_src),      32'(m_src));
        checkOutput("fifo_cnt",     32'(fifo_cnt),     32'(mq.size()));
        checkOutput("timeout_err",  32'(timeout_err),  32'(m_err));
        checkOutput("uart_done",    32'(uart_done),    32'(fin && !m_src));
        checkOutput("tour_done",    32'(tour_done),    32'(fin && m_src));

        if (tmo) m_err = 1;
        else if (err_clr) m_err = 0;
        case (m_phase)
            0: begin
                if (tour_go) begin
                    m_cmd = tour_cmd; m_src = 1; m_phase = 1;
                end else if (uart_go) begin
                    m_cmd = mq.pop_front(); m_src = 0; m_phase = 1;
                end
            end
            1: if (clr_cmd_rdy) begin m_phase = 2; m_wait = 0; end
            default: if (fin) m_phase = 0; else m_wait++;
        endcase
        if (m_accept) mq.push_back(uart_cmd);

        @(posedge clk);
        #1;
    endtask

    // Acts as a prompt cmd_proc and a UART feeding to_push, recording issue order.
    task automatic serveUntil(input int n);
        bit pend = 0;
        issued.delete();
        for (int c = 0; c < 80 && issued.size() < n; c++) begin
            uart_cmd_rdy = (to_push.size() != 0);
            if (to_push.size() != 0) uart_cmd = to_push[0];
            send_resp   = pend;
            clr_cmd_rdy = cmd_rdy;
            pend        = cmd_rdy;
            if (cmd_rdy) issued.push_back(cmd);
            applyStimulus();
            if (m_accept) void'(to_push.pop_front());
        end
        uart_cmd_rdy = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b1;
        applyStimulus();
        send_resp    = 1'b0;
        applyStimulus();
        checkOutput("serve_count", 32'(issued.size()), 32'(n));
    endtask

    initial begin
        bit silent = 0;

        doReset();
        checkOutput("rst_cmd", 32'(cmd), 32'h0);
        checkOutput("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        checkOutput("rst_fifo_cnt", 32'(fifo_cnt), 32'h0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);

        // Single UART command end to end.
        uart_cmd = 16'h4021; uart_cmd_rdy = 1'b1;
        applyStimulus();
        uart_cmd_rdy = 1'b0;
        applyStimulus();
        checkOutput("uart1_cmd", 32'(cmd), 32'h4021);
        checkOutput("uart1_cmd_rdy", 32'(cmd_rdy), 32'h1);
        checkOutput("uart1_src", 32'(cur_src), 32'h0);
        clr_cmd_rdy = 1'b1; applyStimulus(); clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        #1 checkOutput("uart1_done", 32'(uart_done), 32'h1);
        applyStimulus();
        send_resp = 1'b0;
        applyStimulus();

        // Fill the FIFO under a tour, overflow is back-pressured, tour goes first.
        tour_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_cmd = 16'h1000 + 16'(i); uart_cmd_rdy = 1'b1;
            applyStimulus();
        end
        uart_cmd = 16'h1004;
        applyStimulus();
        applyStimulus();
        checkOutput("full_cnt", 32'(fifo_cnt), 32'h4);
        checkOutput("full_held", 32'(clr_uart_rdy), 32'h0);
        tour_cmd = 16'h47F2; tour_cmd_rdy = 1'b1;
        #1 checkOutput("tour_ack", 32'(clr_tour_rdy), 32'h1);
        applyStimulus();
        tour_cmd_rdy = 1'b0;
        checkOutput("tour_cmd", 32'(cmd), 32'h47F2);
        checkOutput("tour_src", 32'(cur_src), 32'h1);
        clr_cmd_rdy = 1'b1; applyStimulus(); clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        #1 checkOutput("tour_done_pulse", 32'(tour_done), 32'h1);
        applyStimulus();
        send_resp = 1'b0;
        tour_active = 1'b0;
        to_push.delete();
        to_push.push_back(16'h1004);
        serveUntil(5);
        for (int k = 0; k < 5 && k < issued.size(); k++)
            checkOutput("drain_order", 32'(issued[k]), 32'h1000 + 32'(k));

        // Response timeout, then clear.
        uart_cmd = 16'hBEEF; uart_cmd_rdy = 1'b1; applyStimulus();
        uart_cmd_rdy = 1'b0; applyStimulus();
        checkOutput("tmo_cmd", 32'(cmd), 32'hBEEF);
        clr_cmd_rdy = 1'b1; applyStimulus(); clr_cmd_rdy = 1'b0;
        repeat (TMO - 1) applyStimulus();
        checkOutput("tmo_done", 32'(uart_done), 32'h1);
        checkOutput("tmo_err_not_yet", 32'(timeout_err), 32'h0);
        applyStimulus();
        checkOutput("tmo_err_set", 32'(timeout_err), 32'h1);
        err_clr = 1'b1; applyStimulus(); err_clr = 1'b0;
        checkOutput("tmo_err_clr", 32'(timeout_err), 32'h0);

        // Reset while a tour command is executing with three UART words queued.
        tour_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uart_cmd = 16'h3000 + 16'(i); uart_cmd_rdy = 1'b1;
            applyStimulus();
        end
        uart_cmd_rdy = 1'b0;
        tour_cmd = 16'h5A5A; tour_cmd_rdy = 1'b1; applyStimulus();
        tour_cmd_rdy = 1'b0; applyStimulus();
        clr_cmd_rdy = 1'b1; applyStimulus(); clr_cmd_rdy = 1'b0;
        applyStimulus();
        checkOutput("pre_rst_cnt", 32'(fifo_cnt), 32'h3);
        tour_active = 1'b0;
        doReset();
        checkOutput("mid_rst_cnt", 32'(fifo_cnt), 32'h0);
        checkOutput("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        checkOutput("mid_rst_cmd", 32'(cmd), 32'h0);
        checkOutput("mid_rst_tour_done", 32'(tour_done), 32'h0);
        send_resp = 1'b1; applyStimulus(); send_resp = 1'b0;

        // Push and pop on the same edge at two entries, order kept across pointer wrap.
        tour_active = 1'b1;
        uart_cmd = 16'h2000; uart_cmd_rdy = 1'b1; applyStimulus();
        uart_cmd = 16'h2001; applyStimulus();
        tour_active = 1'b0;
        uart_cmd = 16'h2002;
        #1 checkOutput("pp_ack", 32'(clr_uart_rdy), 32'h1);
        applyStimulus();
        checkOutput("pp_cnt", 32'(fifo_cnt), 32'h2);
        to_push.delete();
        for (int i = 3; i < 8; i++) to_push.push_back(16'h2000 + 16'(i));
        serveUntil(8);
        for (int k = 0; k < 8 && k < issued.size(); k++)
            checkOutput("wrap_order", 32'(issued[k]), 32'h2000 + 32'(k));

        // Randomized traffic against the model.
        to_push.delete();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                if (to_push.size() == 0 && $urandom_range(0, 2) == 0)
                    to_push.push_back(16'($urandom));
                uart_cmd_rdy = (to_push.size() != 0);
                if (to_push.size() != 0) uart_cmd = to_push[0];
                if ($urandom_range(0, 29) == 0) tour_active = !tour_active;
                if (!tour_cmd_rdy && $urandom_range(0, 3) == 0) begin
                    tour_cmd_rdy = 1'b1;
                    tour_cmd = 16'($urandom);
                end
                if ($urandom_range(0, 49) == 0) silent = !silent;
                clr_cmd_rdy = ($urandom_range(0, 1) == 1);
                send_resp   = !silent && ($urandom_range(0, 3) == 0);
                err_clr     = ($urandom_range(0, 19) == 0);
                applyStimulus();
                if (m_accept) void'(to_push.pop_front());
                if (m_tour_take) tour_cmd_rdy = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
